// File: rtl/mic_word_fifo.sv
// mic_word_fifo: buffers packed mu-law words from the microphone stage
// for the monitor transmitter. Upstream uses a valid/registered-acknowledge
// handshake; downstream uses valid/ready. Two saturating counters record
// back-pressure episodes and reads attempted while empty.
module mic_word_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              mic_data,
    input  logic                     mic_data_valid,
    output logic                     mic_data_retrieved,
    input  logic                     flush,
    output logic [31:0]              tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         overflow_count,
    output logic [CNT_W-1:0]         underrun_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [31:0]    mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic           ack_q, ack_d;
    logic           ovf_cond_q, ovf_cond_d;
    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic [CNT_W-1:0] und_cnt_q, und_cnt_d;

    logic full, empty, accept, pop;

    // Handshake decisions and next-state for pointers, level and counters.
    // Full is judged on the level before this cycle's pop, so a pop never
    // opens room for a push in the same cycle. The ack guard stops a second
    // capture while upstream is still dropping valid.
    always_comb begin
        full       = (level_q == LW'(DEPTH));
        empty      = (level_q == '0);
        accept     = mic_data_valid && !full && !ack_q && !flush;
        pop        = !empty && tx_ready && !flush;
        ovf_cond_d = mic_data_valid && full;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ack_d    = accept;
        ovf_cnt_d = ovf_cnt_q;
        und_cnt_d = und_cnt_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (accept) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);
            level_d = level_q + LW'(accept) - LW'(pop);
        end

        // One count per back-pressure episode: only the rising edge of the condition.
        if (ovf_cond_d && !ovf_cond_q && (ovf_cnt_q != '1))
            ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
        if (tx_ready && empty && !flush && (und_cnt_q != '1))
            und_cnt_d = und_cnt_q + CNT_W'(1);
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ack_q      <= 1'b0;
            ovf_cond_q <= 1'b0;
            ovf_cnt_q  <= '0;
            und_cnt_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ack_q      <= ack_d;
            ovf_cond_q <= ovf_cond_d;
            ovf_cnt_q  <= ovf_cnt_d;
            und_cnt_q  <= und_cnt_d;
        end
    end

    // Word storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (rst_n && accept)
            mem_q[wr_ptr_q] <= mic_data;
    end

    // Head word is masked to zero when empty so stale storage never shows.
    always_comb begin
        tx_valid           = !empty;
        tx_data            = empty ? 32'h0 : mem_q[rd_ptr_q];
        mic_data_retrieved = ack_q;
        level              = level_q;
        overflow_count     = ovf_cnt_q;
        underrun_count     = und_cnt_q;
    end

endmodule

// File: tb/tb_mic_word_fifo.sv
// Bench for mic_word_fifo: a behavioural queue model predicts acknowledges,
// level and counters; accepted words go to a scoreboard and are compared as
// the transmitter pops them.
module tb_mic_word_fifo;

    localparam int DEPTH = 4;
    localparam int MAXC  = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] mic_data;
    logic        mic_data_valid;
    logic        mic_data_retrieved;
    logic        flush;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [2:0]  level;
    logic [7:0]  overflow_count;
    logic [7:0]  underrun_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] sb[$];
    int          m_level, m_ovf, m_und;
    logic        m_ack, m_oprev;
    logic        m_popped;
    logic [31:0] pop_act, pop_exp;

    mic_word_fifo #(.DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .mic_data(mic_data), .mic_data_valid(mic_data_valid),
        .mic_data_retrieved(mic_data_retrieved), .flush(flush),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .level(level), .overflow_count(overflow_count),
        .underrun_count(underrun_count)
    );

    always #5 clk = ~clk;

    // Advance one clock, updating the reference model from the inputs seen at the edge.
    task automatic tick();
        logic acc, pop, oc;
        m_popped = 1'b0;
        if (!rst_n) begin
            sb.delete();
            m_level = 0; m_ack = 1'b0; m_ovf = 0; m_und = 0; m_oprev = 1'b0;
        end else begin
            acc = mic_data_valid && (m_level < DEPTH) && !m_ack && !flush;
            pop = (m_level != 0) && tx_ready && !flush;
            oc  = mic_data_valid && (m_level == DEPTH);
            if (oc && !m_oprev && m_ovf != MAXC) m_ovf++;
            m_oprev = oc;
            if (tx_ready && m_level == 0 && !flush && m_und != MAXC) m_und++;
            if (pop) begin
                m_popped = 1'b1;
                pop_act  = tx_data;
                pop_exp  = sb.pop_front();
            end
            if (flush) begin
                sb.delete();
                m_level = 0;
            end else begin
                if (acc) sb.push_back(mic_data);
                m_level = m_level + int'(acc) - int'(pop);
            end
            m_ack = acc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; mic_data = '0; mic_data_valid = 1'b0; flush = 1'b0; tx_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        total++; if (mic_data_retrieved !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", mic_data_retrieved); end
        total++; if (tx_data !== 32'h0) begin bad++; $display("FAIL reset_tx_data got=%h exp=0", tx_data); end
        total++; if (overflow_count !== 8'd0 || underrun_count !== 8'd0) begin
            bad++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", overflow_count, underrun_count);
        end
    endtask

    task automatic test_single();
        do_reset();
        mic_data = 32'h12345678; mic_data_valid = 1'b1;
        tick();
        total++; if (mic_data_retrieved !== 1'b1) begin bad++; $display("FAIL single_ack got=%b exp=1", mic_data_retrieved); end
        total++; if (tx_valid !== 1'b1 || tx_data !== 32'h12345678) begin
            bad++; $display("FAIL single_head got=%b/%h exp=1/12345678", tx_valid, tx_data);
        end
        total++; if (level !== 3'd1) begin bad++; $display("FAIL single_level got=%0d exp=1", level); end
        mic_data_valid = 1'b0;
        tick();
        total++; if (mic_data_retrieved !== 1'b0) begin bad++; $display("FAIL single_ack_one_cycle got=%b exp=0", mic_data_retrieved); end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        total++; if (!m_popped || pop_act !== 32'h12345678) begin
            bad++; $display("FAIL single_pop got=%h exp=12345678", pop_act);
        end
        total++; if (level !== 3'd0 || tx_valid !== 1'b0) begin
            bad++; $display("FAIL single_drain got=%0d/%b exp=0/0", level, tx_valid);
        end
    endtask

    task automatic test_fill();
        int idx, acks, pops;
        do_reset();
        idx = 1; acks = 0; pops = 0;
        mic_data = 32'h1; mic_data_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            total++; if (mic_data_retrieved !== m_ack) begin bad++; $display("FAIL fill_ack c=%0d got=%b exp=%b", c, mic_data_retrieved, m_ack); end
            if (m_ack) begin
                acks++; idx++;
                if (idx <= 5) mic_data = 32'(idx); else mic_data_valid = 1'b0;
            end
        end
        total++; if (acks != 4) begin bad++; $display("FAIL fill_acks got=%0d exp=4", acks); end
        total++; if (level !== 3'd4) begin bad++; $display("FAIL fill_level got=%0d exp=4", level); end
        total++; if (overflow_count !== 8'd1) begin bad++; $display("FAIL fill_overflow got=%0d exp=1", overflow_count); end
        total++; if (tx_data !== 32'h1) begin bad++; $display("FAIL fill_head got=%h exp=1", tx_data); end
        tx_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (m_popped) begin
                pops++;
                total++; if (pop_act !== pop_exp) begin bad++; $display("FAIL fill_pop n=%0d got=%h exp=%h", pops, pop_act, pop_exp); end
            end
            total++; if (mic_data_retrieved !== m_ack) begin bad++; $display("FAIL fill_drain_ack c=%0d got=%b exp=%b", c, mic_data_retrieved, m_ack); end
            if (m_ack) begin
                acks++; idx++;
                if (idx <= 5) mic_data = 32'(idx); else mic_data_valid = 1'b0;
            end
        end
        tx_ready = 1'b0;
        total++; if (acks != 5 || pops != 5) begin bad++; $display("FAIL fill_totals got=%0d/%0d exp=5/5", acks, pops); end
        total++; if (overflow_count !== 8'd1) begin bad++; $display("FAIL fill_overflow_after got=%0d exp=1", overflow_count); end
        total++; if (underrun_count !== 8'(m_und)) begin bad++; $display("FAIL fill_underrun got=%0d exp=%0d", underrun_count, m_und); end
    endtask

    task automatic test_stream();
        int acks, pops;
        do_reset();
        acks = 0; pops = 0;
        mic_data = $urandom; mic_data_valid = 1'b1;
        for (int c = 0; c < 200 && pops < 40; c++) begin
            tick();
            if (m_popped) begin
                pops++;
                total++; if (pop_act !== pop_exp) begin bad++; $display("FAIL stream_pop n=%0d got=%h exp=%h", pops, pop_act, pop_exp); end
            end
            total++; if (mic_data_retrieved !== m_ack || level !== 3'(m_level) || level > 3'd1) begin
                bad++; $display("FAIL stream_state c=%0d got=%b/%0d exp=%b/%0d", c, mic_data_retrieved, level, m_ack, m_level);
            end
            if (m_ack) begin
                acks++;
                if (acks < 40) mic_data = $urandom; else mic_data_valid = 1'b0;
            end
            tx_ready = tx_valid;
        end
        tx_ready = 1'b0; mic_data_valid = 1'b0;
        total++; if (acks != 40 || pops != 40) begin bad++; $display("FAIL stream_totals got=%0d/%0d exp=40/40", acks, pops); end
        total++; if (overflow_count !== 8'd0 || underrun_count !== 8'd0) begin
            bad++; $display("FAIL stream_counters got=%0d/%0d exp=0/0", overflow_count, underrun_count);
        end
    endtask

    task automatic test_underrun();
        do_reset();
        tx_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL underrun_valid c=%0d got=%b exp=0", c, tx_valid); end
        end
        total++; if (underrun_count !== 8'd3) begin bad++; $display("FAIL underrun_three got=%0d exp=3", underrun_count); end
        for (int c = 0; c < 300; c++) tick();
        tx_ready = 1'b0;
        total++; if (underrun_count !== 8'd255) begin bad++; $display("FAIL underrun_saturate got=%0d exp=255", underrun_count); end
    endtask

    task automatic test_flush();
        int acks;
        logic [7:0] ovf_b, und_b;
        do_reset();
        acks = 0;
        mic_data = 32'hA0; mic_data_valid = 1'b1;
        for (int c = 0; c < 12 && acks < 3; c++) begin
            tick();
            if (m_ack) begin acks++; mic_data = mic_data + 32'h1; end
        end
        mic_data_valid = 1'b0;
        tick();
        total++; if (level !== 3'd3) begin bad++; $display("FAIL flush_prefill got=%0d exp=3", level); end
        ovf_b = overflow_count; und_b = underrun_count;
        flush = 1'b1; mic_data_valid = 1'b1; mic_data = 32'hDEAD0001; tx_ready = 1'b1;
        tick();
        flush = 1'b0; mic_data_valid = 1'b0; tx_ready = 1'b0;
        total++; if (level !== 3'd0 || tx_valid !== 1'b0) begin bad++; $display("FAIL flush_empty got=%0d/%b exp=0/0", level, tx_valid); end
        total++; if (mic_data_retrieved !== 1'b0) begin bad++; $display("FAIL flush_no_ack got=%b exp=0", mic_data_retrieved); end
        total++; if (overflow_count !== ovf_b || underrun_count !== und_b) begin
            bad++; $display("FAIL flush_counters got=%0d/%0d exp=%0d/%0d", overflow_count, underrun_count, ovf_b, und_b);
        end
        mic_data = 32'hBEEF0002; mic_data_valid = 1'b1;
        tick();
        mic_data_valid = 1'b0; flush = 1'b1;
        total++; if (mic_data_retrieved !== 1'b1) begin bad++; $display("FAIL flush_pending_ack got=%b exp=1", mic_data_retrieved); end
        tick();
        flush = 1'b0;
        total++; if (level !== 3'd0 || tx_valid !== 1'b0 || mic_data_retrieved !== 1'b0) begin
            bad++; $display("FAIL flush_discard got=%0d/%b/%b exp=0/0/0", level, tx_valid, mic_data_retrieved);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        mic_data = 32'h11; mic_data_valid = 1'b1;
        tick();
        mic_data_valid = 1'b0;
        tick();
        mic_data = 32'h22; mic_data_valid = 1'b1;
        tick();
        mic_data_valid = 1'b0;
        total++; if (level !== 3'd2 || mic_data_retrieved !== 1'b1 || underrun_count !== 8'd1) begin
            bad++; $display("FAIL rstmid_setup got=%0d/%b/%0d exp=2/1/1", level, mic_data_retrieved, underrun_count);
        end
        rst_n = 1'b0;
        tick();
        total++; if (level !== 3'd0 || mic_data_retrieved !== 1'b0 || tx_valid !== 1'b0) begin
            bad++; $display("FAIL rstmid_state got=%0d/%b/%b exp=0/0/0", level, mic_data_retrieved, tx_valid);
        end
        total++; if (underrun_count !== 8'd0 || overflow_count !== 8'd0 || tx_data !== 32'h0) begin
            bad++; $display("FAIL rstmid_out got=%0d/%0d/%h exp=0/0/0", underrun_count, overflow_count, tx_data);
        end
        rst_n = 1'b1;
        tick();
        total++; if (mic_data_retrieved !== 1'b0) begin bad++; $display("FAIL rstmid_no_ack got=%b exp=0", mic_data_retrieved); end
        mic_data = 32'h33; mic_data_valid = 1'b1;
        tick();
        mic_data_valid = 1'b0;
        total++; if (mic_data_retrieved !== 1'b1 || tx_data !== 32'h33) begin
            bad++; $display("FAIL rstmid_resume got=%b/%h exp=1/33", mic_data_retrieved, tx_data);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; mic_data = '0; mic_data_valid = 1'b0; flush = 1'b0; tx_ready = 1'b0;
        m_level = 0; m_ovf = 0; m_und = 0; m_ack = 1'b0; m_oprev = 1'b0; m_popped = 1'b0;
        pop_act = '0; pop_exp = '0;
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_underrun();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
